// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the serial subtractor:
//   - state_t       : controller states (IDLE, RUN, DONE)
//   - calc_steps    : number of slice steps for one operation
//   - calc_cnt_width: width of the step counter (at least 1 bit)
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    // A one-step operation still needs a 1-bit counter to exist.
    function automatic int calc_cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_borrow_slice.sv
// borrow_slice
//   Purely combinational N-bit ripple-borrow subtractor: d = x - y - bi.
//   Ports:
//     x  [N] : minuend slice
//     y  [N] : subtrahend slice
//     bi     : borrow into bit 0
//     d  [N] : difference slice
//     bo     : borrow out of bit N-1
module borrow_slice #(
    parameter int N = 1
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bi,
    output logic [N-1:0] d,
    output logic         bo
);

    // chain[i] is the borrow into bit i.
    logic [N:0] chain;

    assign chain[0] = bi;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign d[i]       = x[i] ^ y[i] ^ chain[i];
        assign chain[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain[i]);
    end

    assign bo = chain[N];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), processed
//   BITS_PER_CYCLE bits per clock with the borrow kept in a flip-flop.
//   Ports:
//     clk, rst             : clock, synchronous active-high reset
//     in_valid / in_ready  : operand handshake (a, b, bin)
//     out_valid / out_ready: result handshake (diff, bout, ovf, neg, zero)
//     bout                 : unsigned borrow-out (a < b + bin)
//     ovf                  : signed two's-complement overflow
//     neg, zero            : sign bit of diff, diff == 0
//     state_dbg            : current controller state (serial_sub_pkg::state_t)
//
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both high. in_ready is high only in IDLE; out_valid is held high,
//   with diff and flags stable, until out_ready is seen high.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             neg,
    output logic             zero,
    output logic [1:0]       state_dbg
);

    localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
    localparam int CW    = calc_cnt_width(STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH exactly");
    end

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic [WIDTH-1:0] a_shift, b_shift, diff_shift;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             sign_a, sign_b;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q, ovf_q, neg_q, zero_q, out_valid_q;

    logic [BITS_PER_CYCLE-1:0] slice_d;
    logic                      slice_bo;

    borrow_slice #(
        .N (BITS_PER_CYCLE)
    ) u_slice (
        .x  (a_sr[BITS_PER_CYCLE-1:0]),
        .y  (b_sr[BITS_PER_CYCLE-1:0]),
        .bi (brw_q),
        .d  (slice_d),
        .bo (slice_bo)
    );

    // Each slice result enters at the top of diff_sr, so after STEPS shifts
    // the first (least significant) slice has reached the bottom.
    if (STEPS == 1) begin : g_one_step
        assign a_shift    = '0;
        assign b_shift    = '0;
        assign diff_shift = slice_d;
    end else begin : g_multi_step
        assign a_shift    = a_sr >> BITS_PER_CYCLE;
        assign b_shift    = b_sr >> BITS_PER_CYCLE;
        assign diff_shift = {slice_d, diff_sr[WIDTH-1:BITS_PER_CYCLE]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)                   state_d = RUN;
            RUN:  if (cnt_q == LAST_STEP)         state_d = DONE;
            DONE: if (out_valid_q && out_ready)   state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // Datapath. The first DONE cycle registers diff and the flags from the
    // finished shift register; out_valid rises with them so outputs only
    // ever change while out_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            diff_sr     <= '0;
            cnt_q       <= '0;
            brw_q       <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        brw_q  <= bin;
                        sign_a <= a[WIDTH-1];
                        sign_b <= b[WIDTH-1];
                        cnt_q  <= '0;
                    end
                end
                RUN: begin
                    a_sr    <= a_shift;
                    b_sr    <= b_shift;
                    diff_sr <= diff_shift;
                    brw_q   <= slice_bo;
                    cnt_q   <= cnt_q + CW'(1);
                end
                DONE: begin
                    if (!out_valid_q) begin
                        diff_q      <= diff_sr;
                        bout_q      <= brw_q;
                        ovf_q       <= (sign_a != sign_b) && (diff_sr[WIDTH-1] != sign_a);
                        neg_q       <= diff_sr[WIDTH-1];
                        zero_q      <= (diff_sr == '0);
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign neg       = neg_q;
    assign zero      = zero_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Four instances of serial_subtractor:
//     0: WIDTH=8,  BPC=1   1: WIDTH=8,  BPC=2
//     2: WIDTH=16, BPC=16  3: WIDTH=16, BPC=4
//   Expected results are queued at issue time and popped by per-instance
//   monitors when a result handshake occurs.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [4];
    logic        in_valid  [4];
    logic        out_ready [4];
    logic [15:0] a         [4];
    logic [15:0] b         [4];
    logic        bin       [4];

    wire         in_ready  [4];
    wire         out_valid [4];
    wire         bout      [4];
    wire         ovf       [4];
    wire         neg       [4];
    wire         zero      [4];
    wire [15:0]  diff      [4];
    wire [1:0]   state_dbg [4];
    wire [7:0]   diff_w8_0, diff_w8_1;

    assign diff[0] = {8'h00, diff_w8_0};
    assign diff[1] = {8'h00, diff_w8_1};

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8_b1 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0][7:0]), .b(b[0][7:0]), .bin(bin[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .diff(diff_w8_0),
        .bout(bout[0]), .ovf(ovf[0]), .neg(neg[0]), .zero(zero[0]), .state_dbg(state_dbg[0])
    );

    serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_w8_b2 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1][7:0]), .b(b[1][7:0]), .bin(bin[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .diff(diff_w8_1),
        .bout(bout[1]), .ovf(ovf[1]), .neg(neg[1]), .zero(zero[1]), .state_dbg(state_dbg[1])
    );

    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(16)) u_w16_b16 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .bin(bin[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .diff(diff[2]),
        .bout(bout[2]), .ovf(ovf[2]), .neg(neg[2]), .zero(zero[2]), .state_dbg(state_dbg[2])
    );

    serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_w16_b4 (
        .clk(clk), .rst(rst[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a[3]), .b(b[3]), .bin(bin[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .diff(diff[3]),
        .bout(bout[3]), .ovf(ovf[3]), .neg(neg[3]), .zero(zero[3]), .state_dbg(state_dbg[3])
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    // entry: {instance[1:0], diff[15:0], bout, ovf, neg, zero}
    logic [21:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: widened subtraction, borrow is the extra top bit.
    function automatic logic [19:0] model(input int w, input logic [15:0] aa,
                                          input logic [15:0] bb, input logic bi);
        logic [16:0] full;
        logic [15:0] d;
        logic        bo, sa, sb, sd;
        if (w == 8) begin
            full = {9'h000, aa[7:0]} - {9'h000, bb[7:0]} - 17'(bi);
            d    = {8'h00, full[7:0]};
            bo   = full[8];
            sa   = aa[7];
            sb   = bb[7];
            sd   = d[7];
        end else begin
            full = {1'b0, aa} - {1'b0, bb} - 17'(bi);
            d    = full[15:0];
            bo   = full[16];
            sa   = aa[15];
            sb   = bb[15];
            sd   = d[15];
        end
        return {d, bo, (sa != sb) && (sd != sa), sd, (d == 16'h0000)};
    endfunction

    // ---------------- monitors ----------------
    for (genvar g = 0; g < 4; g++) begin : g_mon
        logic [21:0] e;
        always @(negedge clk) begin
            if (!rst[g] && out_valid[g] && out_ready[g]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result inst=%0d: actual diff=%h required no result",
                             g, diff[g]);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("result_inst_tag%0d", g), 32'(g), 32'(e[21:20]));
                    check($sformatf("result_inst%0d", g),
                          {12'h0, diff[g], bout[g], ovf[g], neg[g], zero[g]}, {12'h0, e[19:0]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int k, input logic [15:0] aa, input logic [15:0] bb, input logic bi);
        int t = 0;
        while (!in_ready[k] && t < 50) begin
            next_cycle();
            t++;
        end
        if (!in_ready[k]) check("in_ready_timeout", 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        a[k]        = aa;
        b[k]        = bb;
        bin[k]      = bi;
        next_cycle();
        in_valid[k] = 1'b0;
    endtask

    task automatic start_op(input int k, input logic [15:0] aa, input logic [15:0] bb,
                            input logic bi, input logic [19:0] exp, input int lat);
        int cyc = 0;
        exp_q.push_back({2'(k), exp});
        accept(k, aa, bb, bi);
        while (!out_valid[k] && cyc < 60) begin
            next_cycle();
            cyc++;
        end
        check($sformatf("latency_inst%0d", k), 32'(cyc), 32'(lat));
    endtask

    task automatic finish_op(input int k);
        int t = 0;
        while (out_valid[k] && t < 50) begin
            next_cycle();
            t++;
        end
        if (out_valid[k]) check("out_valid_stuck", 32'(out_valid[k]), 32'd0);
    endtask

    task automatic run_op(input int k, input logic [15:0] aa, input logic [15:0] bb,
                          input logic bi, input logic [19:0] exp, input int lat);
        start_op(k, aa, bb, bi, exp, lat);
        finish_op(k);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ra, rb;
        logic        rbi;
        int          t;

        for (int k = 0; k < 4; k++) begin
            rst[k]       = 1'b1;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            a[k]         = '0;
            b[k]         = '0;
            bin[k]       = 1'b0;
        end
        repeat (3) next_cycle();
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;

        // Reset state of every instance
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset_state_inst%0d", k),
                  {8'h0, in_ready[k], out_valid[k], diff[k], bout[k], ovf[k], neg[k], zero[k], state_dbg[k]},
                  {8'h0, 1'b1, 1'b0, 16'h0000, 4'b0000, 2'(IDLE)});
        end

        // WIDTH=8, BPC=1 ; flags are {bout, ovf, neg, zero}
        run_op(0, 16'h05, 16'h03, 1'b0, {16'h0002, 4'b0000}, 9);
        run_op(0, 16'h03, 16'h05, 1'b0, {16'h00FE, 4'b1010}, 9);
        run_op(0, 16'h00, 16'h00, 1'b1, {16'h00FF, 4'b1010}, 9);

        // WIDTH=8, BPC=2
        run_op(1, 16'h80, 16'h01, 1'b0, {16'h007F, 4'b0100}, 5);
        run_op(1, 16'h7F, 16'hFF, 1'b0, {16'h0080, 4'b1110}, 5);
        run_op(1, 16'h2A, 16'h2A, 1'b0, {16'h0000, 4'b0001}, 5);
        run_op(1, 16'h10, 16'h0F, 1'b1, {16'h0000, 4'b0001}, 5);

        // WIDTH=16, BPC=16 and BPC=4 corners
        run_op(2, 16'h0000, 16'h0000, 1'b1, {16'hFFFF, 4'b1010}, 2);
        run_op(2, 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 4'b0100}, 2);
        run_op(3, 16'h1234, 16'h0234, 1'b0, {16'h1000, 4'b0000}, 5);
        run_op(3, 16'h7FFF, 16'h8000, 1'b0, {16'hFFFF, 4'b1110}, 5);

        // Backpressure on instance 0: 0x40 - 0x41 = 0xFF
        out_ready[0] = 1'b0;
        start_op(0, 16'h40, 16'h41, 1'b0, {16'h00FF, 4'b1010}, 9);
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = (i % 2 == 0);
            a[0]        = 16'h77;
            b[0]        = 16'h11;
            bin[0]      = 1'b1;
            next_cycle();
            check("backpressure_hold",
                  {8'h0, out_valid[0], in_ready[0], diff[0], bout[0], ovf[0], neg[0], zero[0], state_dbg[0]},
                  {8'h0, 1'b1, 1'b0, 16'h00FF, 4'b1010, 2'(DONE)});
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        next_cycle();
        check("release_in_ready", {31'h0, in_ready[0]}, 32'd1);
        check("release_out_valid", {31'h0, out_valid[0]}, 32'd0);
        repeat (3) next_cycle();
        check("no_late_accept", {30'h0, state_dbg[0]}, 32'(IDLE));

        // Reset in the third RUN cycle: accept edge, RUN edges 1 and 2, reset at edge 3
        accept(0, 16'h55, 16'h22, 1'b0);
        next_cycle();
        next_cycle();
        rst[0] = 1'b1;
        next_cycle();
        rst[0] = 1'b0;
        check("reset_in_run",
              {8'h0, state_dbg[0], out_valid[0], in_ready[0], diff[0], bout[0], ovf[0], neg[0], zero[0]},
              {8'h0, 2'(IDLE), 1'b0, 1'b1, 16'h0000, 4'b0000});

        // Reset while a result is waiting in DONE: it must never be delivered
        out_ready[0] = 1'b0;
        accept(0, 16'h09, 16'h01, 1'b0);
        t = 0;
        while (!out_valid[0] && t < 60) begin
            next_cycle();
            t++;
        end
        check("done_reached_before_reset", {31'h0, out_valid[0]}, 32'd1);
        rst[0] = 1'b1;
        next_cycle();
        rst[0]       = 1'b0;
        out_ready[0] = 1'b1;
        check("reset_in_done",
              {8'h0, state_dbg[0], out_valid[0], in_ready[0], diff[0], bout[0], ovf[0], neg[0], zero[0]},
              {8'h0, 2'(IDLE), 1'b0, 1'b1, 16'h0000, 4'b0000});

        // Fresh operation after reset
        run_op(0, 16'h10, 16'h01, 1'b0, {16'h000F, 4'b0000}, 9);

        // Random vectors on the 16-bit instances
        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            run_op(2, ra, rb, rbi, model(16, ra, rb, rbi), 2);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            run_op(3, ra, rb, rbi, model(16, ra, rb, rbi), 5);
        end

        repeat (3) next_cycle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
